bcd_counter_display: RTL and testbench
======================================

BCD_COUNTER_DISPLAY -- requirements
Module: bcd_counter_display

Interface
REQ-001 Parameter DIGIT_CYCLES, default 22500: clk cycles each digit is driven (90 MHz / 22500 = 4 kHz per digit, 1 kHz full refresh).
REQ-002 clk  input  1  system clock, 90 MHz.
REQ-003 rst  input  1  reset; one clock, asynchronous, active-high.
REQ-004 inc_pulse  input  1  one-cycle increment request from a debouncer, synchronous to clk.
REQ-005 dec_pulse  input  1  one-cycle decrement request from a debouncer.
REQ-006 clr_pulse  input  1  one-cycle clear request from a debouncer.
REQ-007 count  output  16  registered value, 4 packed BCD digits, [3:0] = units.
REQ-008 wrap  output  1  one-cycle pulse on 9999->0000 or 0000->9999.
REQ-009 an  output  4  digit enables, active-low, one-hot-zero, an[0] = units.
REQ-010 seg  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
REQ-011 dp  output  1  decimal point, active-low, constant 1 (off).

Function
REQ-012 Priority per cycle SHALL be:
  - clr_pulse: count <= 0000, no wrap pulse.
  - else inc_pulse and dec_pulse together: no change.
  - else inc_pulse: +1.
  - else dec_pulse: -1.
REQ-013 Increment SHALL use decimal carry: a digit at 9 becomes 0 and carries, e.g. 0199 -> 0200.
REQ-014 Decrement SHALL use decimal borrow: a digit at 0 becomes 9 and borrows, e.g. 0200 -> 0199.
REQ-015 9999 + 1 SHALL give 0000 with wrap = 1 for exactly one cycle; 0000 - 1 SHALL give 9999 with wrap = 1 for exactly one cycle.
REQ-016 count and wrap SHALL update on the clk edge that samples the request pulse (latency 1 cycle); a pulse held high N cycles SHALL act N times.
REQ-017 Scan: dwell counter 0..DIGIT_CYCLES-1; at DIGIT_CYCLES-1 it SHALL reset to 0 and digit index SHALL advance 0->1->2->3->0.
REQ-018 an SHALL be registered: index 0 -> 1110, 1 -> 1101, 2 -> 1011, 3 -> 0111.
REQ-019 seg SHALL be registered from the current index and the count value at the same edge, with no extra pipeline skew versus an.
REQ-020 Digit codes, active-low:
  - 0 -> 1000000, 1 -> 1111001, 2 -> 0100100, 3 -> 0110000, 4 -> 0011001.
  - 5 -> 0010010, 6 -> 0000010, 7 -> 1111000, 8 -> 0000000, 9 -> 0010000.
REQ-021 Leading-zero blanking: a digit SHALL be blanked (seg = 1111111, an still asserted) when it and every more-significant digit are 0; the units digit SHALL never be blanked.
REQ-022 Count changes mid-dwell SHALL appear on seg at the next edge without restarting the scan.
REQ-023 dp SHALL be 1 at all times.

Reset
REQ-024 While rst = 1, the block SHALL hold count = 0000, wrap = 0, an = 1111, seg = 1111111, dp = 1, dwell counter = 0, digit index = 0, independent of clk.
REQ-025 On the first clk edge after rst falls, the block SHALL drive an = 1110 and seg = 1000000.
REQ-026 Requests sampled while rst = 1 SHALL be ignored.
REQ-027 Asserting rst mid-dwell or mid-wrap SHALL force the REQ-024 values immediately.

Structure
REQ-028 A shared package SHALL hold the ten segment constants, the blank constant, and NUM_DIGITS = 4.
REQ-029 One sub-module, bcd_digit, SHALL be used, instantiated four times in a chain:
  - inputs: up, down, carry/borrow in, clr.
  - outputs: 4-bit value, carry/borrow out.
REQ-030 The scan counter and segment decode SHALL live in the top module.
REQ-031 Benches SHALL override DIGIT_CYCLES to 4.

Verification
REQ-032 Reset release, no requests, DIGIT_CYCLES = 4 -> an cycles 1110, 1101, 1011, 0111 every 4 clocks; seg = 1000000 only while an = 1110, otherwise 1111111.
REQ-033 Load 0199, one inc_pulse -> count = 0200 next cycle; digit 2 shows 0100100, digit 3 blanked.
REQ-034 Count = 9999, inc_pulse -> count = 0000, wrap high exactly 1 cycle; then dec_pulse -> 9999, wrap high 1 cycle.
REQ-035 inc and dec in the same cycle at 0042 -> stays 0042; clr with inc at 0042 -> 0000, wrap = 0.
REQ-036 rst asserted asynchronously mid-dwell at count 1234 -> an = 1111, seg = 1111111, count = 0000 before the next clk edge.
REQ-037 inc_pulse held 12 cycles from 0000 -> count = 0012.

Source files
------------

// File: rtl/bcd_counter_display_pkg.sv
// Shared constants for the 4-digit BCD counter with a multiplexed 7-segment display.
// Segment patterns are {g,f,e,d,c,b,a}, active-low.
package bcd_counter_display_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bcd_counter_display_digit.sv
// One decade of the up/down BCD counter. Steps only when the carry/borrow input is high;
// carry/borrow out is asserted when this decade rolls over in the requested direction.
module bcd_digit (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_clr,
  input  logic       i_up,
  input  logic       i_down,
  input  logic       i_cin,
  output logic [3:0] o_value,
  output logic       o_cout
);

  logic [3:0] r_value;

  assign o_value = r_value;
  assign o_cout  = i_cin & ((i_up & (r_value == 4'd9)) | (i_down & (r_value == 4'd0)));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_value <= 4'd0;
    end else if (i_clr) begin
      r_value <= 4'd0;
    end else if (i_cin && i_up) begin
      r_value <= (r_value == 4'd9) ? 4'd0 : r_value + 4'd1;
    end else if (i_cin && i_down) begin
      r_value <= (r_value == 4'd0) ? 4'd9 : r_value - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_counter_display.sv
// Four-digit up/down BCD counter driving a time-multiplexed, active-low 7-segment display
// with leading-zero blanking.
module bcd_counter_display
  import bcd_counter_display_pkg::*;
#(
  parameter int DIGIT_CYCLES = 22500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc_pulse,
  input  logic        dec_pulse,
  input  logic        clr_pulse,
  output logic [15:0] count,
  output logic        wrap,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int DW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DIGIT_CYCLES - 1);

  logic                  w_up;
  logic                  w_down;
  logic [NUM_DIGITS:0]   w_carry;
  logic [NUM_DIGITS-1:0] w_lead_zero;
  logic [3:0]            w_digit;

  logic                  r_wrap;
  logic [DW-1:0]         r_dwell;
  logic [1:0]            r_idx;
  logic [3:0]            r_an;
  logic [6:0]            r_seg;

  // Simultaneous inc and dec cancel; clear overrides both and never reports a wrap.
  assign w_up       = inc_pulse & ~dec_pulse & ~clr_pulse;
  assign w_down     = dec_pulse & ~inc_pulse & ~clr_pulse;
  assign w_carry[0] = w_up | w_down;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      bcd_digit u_digit (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_clr   (clr_pulse),
        .i_up    (w_up),
        .i_down  (w_down),
        .i_cin   (w_carry[gi]),
        .o_value (count[gi*4 +: 4]),
        .o_cout  (w_carry[gi+1])
      );
    end
  endgenerate

  // w_lead_zero[i]: digit i and every more-significant digit are zero.
  always_comb begin
    w_lead_zero = '0;
    w_lead_zero[NUM_DIGITS-1] = (count[(NUM_DIGITS-1)*4 +: 4] == 4'd0);
    for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
      w_lead_zero[i] = (count[i*4 +: 4] == 4'd0) & w_lead_zero[i+1];
    end
  end

  assign w_digit = count[r_idx*4 +: 4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrap  <= 1'b0;
      r_dwell <= '0;
      r_idx   <= 2'd0;
      r_an    <= 4'b1111;
      r_seg   <= SEG_BLANK;
    end else begin
      r_wrap <= w_carry[NUM_DIGITS];
      if (r_dwell == DWELL_LAST) begin
        r_dwell <= '0;
        r_idx   <= r_idx + 2'd1;
      end else begin
        r_dwell <= r_dwell + DW'(1);
      end
      // an and seg both come from the index before this edge, so they never skew.
      r_an  <= ~(4'b0001 << r_idx);
      r_seg <= (w_lead_zero[r_idx] && (r_idx != 2'd0)) ? SEG_BLANK : bcd_to_seg(w_digit);
    end
  end

  assign wrap = r_wrap;
  assign an   = r_an;
  assign seg  = r_seg;
  assign dp   = 1'b1;

endmodule

// File: tb/tb_bcd_counter_display.sv
// Self-checking bench: directed scenarios plus random inc/dec/clr traffic, compared every
// cycle against an integer-arithmetic model of the counter and display scan.
module tb_bcd_counter_display;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        inc_pulse = 1'b0;
  logic        dec_pulse = 1'b0;
  logic        clr_pulse = 1'b0;
  logic [15:0] count;
  logic        wrap;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int vectors = 0;
  int miscompares = 0;
  int mc = 0;     // model count, 0..9999
  int ecnt = 0;   // clock edges since reset release

  bcd_counter_display #(.DIGIT_CYCLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .inc_pulse (inc_pulse),
    .dec_pulse (dec_pulse),
    .clr_pulse (clr_pulse),
    .count     (count),
    .wrap      (wrap),
    .an        (an),
    .seg       (seg),
    .dp        (dp)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] digit_code(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      default: return 7'b0010000;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input int v, input int idx);
    int pw;
    pw = (idx == 0) ? 1 : (idx == 1) ? 10 : (idx == 2) ? 100 : 1000;
    if (idx > 0 && v < pw) return 7'b1111111;
    return digit_code((v / pw) % 10);
  endfunction

  function automatic logic [3:0] exp_an(input int idx);
    case (idx)
      0: return 4'b1110;
      1: return 4'b1101;
      2: return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Apply one cycle of requests from a negedge, check #1 after the posedge, return at negedge.
  task automatic step(input bit i, input bit d, input bit c);
    int prev;
    int idx;
    bit ew;
    inc_pulse = i;
    dec_pulse = d;
    clr_pulse = c;
    @(posedge clk);
    prev = mc;
    ew = 1'b0;
    ecnt++;
    if (c) mc = 0;
    else if (i && d) mc = mc;
    else if (i) begin
      if (mc == 9999) begin mc = 0; ew = 1'b1; end else mc = mc + 1;
    end else if (d) begin
      if (mc == 0) begin mc = 9999; ew = 1'b1; end else mc = mc - 1;
    end
    idx = ((ecnt - 1) / 4) % 4;
    #1;
    chk("count", count, to_bcd(mc));
    chk("wrap", {15'd0, wrap}, {15'd0, ew});
    chk("an", {12'd0, an}, {12'd0, exp_an(idx)});
    chk("seg", {9'd0, seg}, {9'd0, exp_seg(prev, idx)});
    chk("dp", {15'd0, dp}, 16'd1);
    @(negedge clk);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_count"}, count, 16'h0000);
    chk({tag, "_wrap"}, {15'd0, wrap}, 16'd0);
    chk({tag, "_an"}, {12'd0, an}, 16'h000F);
    chk({tag, "_seg"}, {9'd0, seg}, 16'h007F);
    chk({tag, "_dp"}, {15'd0, dp}, 16'd1);
  endtask

  initial begin
    int r;
    // Reset, with requests presented during reset that must be ignored.
    #2 rst = 1'b1;
    #1 chk_reset_state("rst_init");
    @(negedge clk);
    inc_pulse = 1'b1;
    dec_pulse = 1'b0;
    @(negedge clk);
    inc_pulse = 1'b0;
    chk_reset_state("rst_held");
    rst = 1'b0;
    mc = 0;
    ecnt = 0;

    // Idle scan: all four digit positions, only units shows '0'.
    for (int k = 0; k < 20; k++) step(0, 0, 0);

    // 0199 -> 0200, then watch a full scan.
    for (int k = 0; k < 199; k++) step(1, 0, 0);
    chk("load_0199", count, 16'h0199);
    step(1, 0, 0);
    chk("carry_0200", count, 16'h0200);
    for (int k = 0; k < 16; k++) step(0, 0, 0);

    // Wrap both ways.
    step(0, 0, 1);
    step(0, 1, 0);
    step(0, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 1, 0);
    step(0, 0, 0);

    // Simultaneous requests at 0042.
    step(0, 0, 1);
    for (int k = 0; k < 42; k++) step(1, 0, 0);
    step(1, 1, 0);
    chk("incdec_0042", count, 16'h0042);
    step(1, 0, 1);
    chk("clrinc_0000", count, 16'h0000);

    // Held increment for 12 cycles.
    for (int k = 0; k < 12; k++) step(1, 0, 0);
    chk("held_0012", count, 16'h0012);

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      r = $urandom_range(99, 0);
      if (r < 3) step(0, 0, 1);
      else if (r < 13) step(1, 1, 0);
      else if (r < 53) step(1, 0, 0);
      else if (r < 83) step(0, 1, 0);
      else step(0, 0, 0);
    end

    // Asynchronous reset mid-dwell at 1234.
    step(0, 0, 1);
    for (int k = 0; k < 1234; k++) step(1, 0, 0);
    step(0, 0, 0);
    chk("pre_async_1234", count, 16'h1234);
    rst = 1'b1;
    #1 chk_reset_state("async_rst");
    @(negedge clk);
    rst = 1'b0;
    mc = 0;
    ecnt = 0;
    for (int k = 0; k < 8; k++) step(0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
